// File: rtl/addr_gen_fft_iter.sv
// Operand, write-back and twiddle address generator for the iterative radix-2 DIT FFT.
// Tracks butterfly/layer counters driven by the FFT control unit strobes.
module addr_gen_fft_iter #(
    parameter int LAYERS      = 5,
    parameter int BUTTERFLYES = 16,
    parameter int LayWL       = 3,
    parameter int ButtWL      = 4,
    parameter int AddrWL      = 5,
    parameter int TwWL        = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              START,
    input  logic              BUT_STROB,
    input  logic              ADDR_EN,
    input  logic              LAY_EN,
    input  logic              FIRST,
    input  logic              Wr,
    output logic [AddrWL-1:0] RD_ADDR_A,
    output logic [AddrWL-1:0] RD_ADDR_B,
    output logic [AddrWL-1:0] WR_ADDR_A,
    output logic [AddrWL-1:0] WR_ADDR_B,
    output logic              WR_EN,
    output logic [TwWL-1:0]   TW_IDX,
    output logic [LayWL-1:0]  LAY,
    output logic              BUSY,
    output logic              DONE
);

    localparam logic [LayWL-1:0]  LAST_L    = LayWL'(LAYERS - 1);
    localparam logic [ButtWL-1:0] BFLY_LAST = ButtWL'(BUTTERFLYES - 1);

    logic [ButtWL-1:0] r_b;
    logic [LayWL-1:0]  r_l;
    logic              r_busy;
    logic              r_done;
    logic              r_wr_en;
    logic [AddrWL-1:0] r_wr_a;
    logic [AddrWL-1:0] r_wr_b;
    logic [AddrWL-1:0] r_hold_rda;
    logic [AddrWL-1:0] r_hold_rdb;
    logic [TwWL-1:0]   r_hold_tw;
    logic [LayWL-1:0]  r_hold_lay;

    logic [AddrWL-1:0] w_bx;
    logic [AddrWL-1:0] w_h;
    logic [AddrWL-1:0] w_g;
    logic [AddrWL-1:0] w_p;
    logic [AddrWL-1:0] w_a;
    logic [AddrWL-1:0] w_bb;
    logic [AddrWL-1:0] w_rda;
    logic [AddrWL-1:0] w_rdb;
    logic [TwWL-1:0]   w_tw_mask;
    logic [LayWL-1:0]  w_tw_sh;
    logic [TwWL-1:0]   w_tw;

    function automatic logic [AddrWL-1:0] bitrev(input logic [AddrWL-1:0] x);
        logic [AddrWL-1:0] y;
        for (int i = 0; i < AddrWL; i++) begin
            y[i] = x[AddrWL-1-i];
        end
        return y;
    endfunction

    // Butterfly b of layer l pairs A = g*2h + p with B = A + h
    assign w_bx      = AddrWL'(r_b);
    assign w_h       = AddrWL'(1) << r_l;
    assign w_g       = w_bx >> r_l;
    assign w_p       = w_bx & ~({AddrWL{1'b1}} << r_l);
    assign w_a       = ((w_g << r_l) << 1) | w_p;
    assign w_bb      = w_a + w_h;
    assign w_rda     = FIRST ? bitrev(w_a)  : w_a;
    assign w_rdb     = FIRST ? bitrev(w_bb) : w_bb;

    assign w_tw_mask = ~({TwWL{1'b1}} << r_l);
    assign w_tw_sh   = LAST_L - r_l;
    assign w_tw      = (TwWL'(r_b) & w_tw_mask) << w_tw_sh;

    // When idle the counters sit at zero, so show the last values seen while busy
    assign RD_ADDR_A = r_busy ? w_rda : r_hold_rda;
    assign RD_ADDR_B = r_busy ? w_rdb : r_hold_rdb;
    assign TW_IDX    = r_busy ? w_tw  : r_hold_tw;
    assign LAY       = r_busy ? r_l   : r_hold_lay;
    assign WR_ADDR_A = r_wr_a;
    assign WR_ADDR_B = r_wr_b;
    assign WR_EN     = r_wr_en;
    assign BUSY      = r_busy;
    assign DONE      = r_done;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_b        <= '0;
            r_l        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_a     <= '0;
            r_wr_b     <= '0;
            r_hold_rda <= '0;
            r_hold_rdb <= '0;
            r_hold_tw  <= '0;
            r_hold_lay <= '0;
        end else if (EN) begin
            r_wr_en <= Wr & r_busy;
            r_done  <= 1'b0;
            if (r_busy) begin
                r_hold_rda <= w_rda;
                r_hold_rdb <= w_rdb;
                r_hold_tw  <= w_tw;
                r_hold_lay <= r_l;
            end
            if (START) begin
                r_b    <= '0;
                r_l    <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                if (BUT_STROB) begin
                    r_wr_a <= w_a;
                    r_wr_b <= w_bb;
                end
                if (ADDR_EN) begin
                    if (!LAY_EN) begin
                        r_b <= (r_b == BFLY_LAST) ? '0 : r_b + 1'b1;
                    end else if (r_l == LAST_L) begin
                        r_b    <= '0;
                        r_l    <= '0;
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_b <= '0;
                        r_l <= r_l + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_addr_gen_fft_iter.sv
// Scoreboard bench for addr_gen_fft_iter: stimulus queues expected snapshots,
// write-backs and DONE pulses; a negedge monitor pops and compares them.
module tb_addr_gen_fft_iter;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       EN = 1'b1, START = 1'b0, BUT_STROB = 1'b0, ADDR_EN = 1'b0;
    logic       LAY_EN = 1'b0, FIRST = 1'b0, Wr = 1'b0;
    logic [4:0] RD_ADDR_A, RD_ADDR_B, WR_ADDR_A, WR_ADDR_B;
    logic       WR_EN, BUSY, DONE;
    logic [3:0] TW_IDX;
    logic [2:0] LAY;

    always #5 CLK = ~CLK;

    addr_gen_fft_iter dut (
        .CLK(CLK), .RST(RST), .EN(EN), .START(START), .BUT_STROB(BUT_STROB),
        .ADDR_EN(ADDR_EN), .LAY_EN(LAY_EN), .FIRST(FIRST), .Wr(Wr),
        .RD_ADDR_A(RD_ADDR_A), .RD_ADDR_B(RD_ADDR_B),
        .WR_ADDR_A(WR_ADDR_A), .WR_ADDR_B(WR_ADDR_B), .WR_EN(WR_EN),
        .TW_IDX(TW_IDX), .LAY(LAY), .BUSY(BUSY), .DONE(DONE)
    );

    typedef struct {
        string      name;
        logic [3:0] mask;
        logic [4:0] rda, rdb, wra, wrb;
        logic [3:0] tw;
        logic [2:0] lay;
        logic       busy, done, wren;
    } snap_t;

    typedef struct {
        logic [4:0] a, b;
    } wr_t;

    localparam int M_RD = 1, M_ST = 2, M_WA = 4, M_WE = 8, M_ALL = 15;

    snap_t q_snap[$];
    wr_t   q_wr[$];
    int    q_done[$];
    int    n_vec = 0;
    int    n_bad = 0;

    task automatic drive(input int en, st, bs, ae, le, fi, w);
        @(posedge CLK);
        #1;
        EN = (en != 0); START = (st != 0); BUT_STROB = (bs != 0);
        ADDR_EN = (ae != 0); LAY_EN = (le != 0); FIRST = (fi != 0); Wr = (w != 0);
    endtask

    task automatic expect_snap(input string nm, input int mask, rda, rdb, tw, lay,
                               busy, done, wra, wrb, wren);
        snap_t s;
        s.name = nm;        s.mask = 4'(mask);
        s.rda = 5'(rda);    s.rdb = 5'(rdb);
        s.tw = 4'(tw);      s.lay = 3'(lay);
        s.busy = (busy != 0); s.done = (done != 0);
        s.wra = 5'(wra);    s.wrb = 5'(wrb);
        s.wren = (wren != 0);
        q_snap.push_back(s);
    endtask

    task automatic expect_wr(input int a, b);
        wr_t w;
        w.a = 5'(a);
        w.b = 5'(b);
        q_wr.push_back(w);
    endtask

    // Monitor
    always @(negedge CLK) begin
        snap_t s;
        wr_t   w;
        logic  ok;
        if (q_snap.size() > 0) begin
            s  = q_snap.pop_front();
            ok = 1'b1;
            if (s.mask[0] && (RD_ADDR_A !== s.rda || RD_ADDR_B !== s.rdb ||
                              TW_IDX !== s.tw || LAY !== s.lay)) ok = 1'b0;
            if (s.mask[1] && (BUSY !== s.busy || DONE !== s.done)) ok = 1'b0;
            if (s.mask[2] && (WR_ADDR_A !== s.wra || WR_ADDR_B !== s.wrb)) ok = 1'b0;
            if (s.mask[3] && (WR_EN !== s.wren)) ok = 1'b0;
            n_vec++;
            if (!ok) begin
                n_bad++;
                $display("FAIL %s (mask %b): got rda=%0d rdb=%0d tw=%0d lay=%0d busy=%b done=%b wra=%0d wrb=%0d wren=%b, want rda=%0d rdb=%0d tw=%0d lay=%0d busy=%b done=%b wra=%0d wrb=%0d wren=%b",
                         s.name, s.mask, RD_ADDR_A, RD_ADDR_B, TW_IDX, LAY, BUSY, DONE,
                         WR_ADDR_A, WR_ADDR_B, WR_EN, s.rda, s.rdb, s.tw, s.lay, s.busy,
                         s.done, s.wra, s.wrb, s.wren);
            end
        end
        if (WR_EN === 1'b1) begin
            n_vec++;
            if (q_wr.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: WR_EN=1 wra=%0d wrb=%0d, want no write",
                         WR_ADDR_A, WR_ADDR_B);
            end else begin
                w = q_wr.pop_front();
                if (WR_ADDR_A !== w.a || WR_ADDR_B !== w.b) begin
                    n_bad++;
                    $display("FAIL write_addr: got wra=%0d wrb=%0d, want wra=%0d wrb=%0d",
                             WR_ADDR_A, WR_ADDR_B, w.a, w.b);
                end
            end
        end
        if (DONE === 1'b1) begin
            n_vec++;
            if (q_done.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done: DONE=1 lay=%0d busy=%b, want DONE=0", LAY, BUSY);
            end else begin
                void'(q_done.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        @(posedge CLK);
        #1;
        expect_snap("reset", M_ALL, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        RST = 1'b1;

        // Start: layer 0, b=0, bit-reversed reads
        drive(1, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 0);
        expect_snap("start_l0_b0", M_ALL, 0, 16, 0, 0, 1, 0, 0, 0, 0);

        // Layer 0, b=3
        repeat (3) drive(1, 0, 0, 1, 0, 1, 0);
        drive(1, 0, 1, 0, 0, 1, 0);
        expect_snap("l0_b3_rd", M_RD | M_ST, 12, 28, 0, 0, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 1);
        expect_snap("l0_b3_wraddr", M_WA | M_WE, 0, 0, 0, 0, 0, 0, 6, 7, 0);
        expect_wr(6, 7);
        drive(1, 0, 0, 0, 0, 1, 0);
        expect_snap("l0_b3_wren", M_WA | M_WE, 0, 0, 0, 0, 0, 0, 6, 7, 1);

        // Layer 2, b=5, natural order
        drive(1, 0, 0, 1, 1, 1, 0);
        drive(1, 0, 0, 1, 1, 0, 0);
        repeat (5) drive(1, 0, 0, 1, 0, 0, 0);
        drive(1, 0, 1, 0, 0, 0, 0);
        expect_snap("l2_b5_rd", M_RD | M_ST, 9, 13, 4, 2, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 1);
        expect_snap("l2_b5_wraddr", M_WA | M_WE, 0, 0, 0, 0, 0, 0, 9, 13, 0);
        expect_wr(9, 13);
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_snap("l2_b5_wren_hi", M_WA | M_WE, 0, 0, 0, 0, 0, 0, 9, 13, 1);
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_snap("l2_b5_wren_lo", M_WA | M_WE, 0, 0, 0, 0, 0, 0, 9, 13, 0);

        // EN low with ADDR_EN held: everything frozen
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 1, 0, 0, 0);
            expect_snap("en_low_hold", M_ALL, 9, 13, 4, 2, 1, 0, 9, 13, 0);
        end
        drive(1, 0, 0, 1, 0, 0, 0);
        expect_snap("en_restore", M_ALL, 9, 13, 4, 2, 1, 0, 9, 13, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_snap("en_resume_b6", M_RD | M_ST, 10, 14, 8, 2, 1, 0, 0, 0, 0);

        // Full transform from a control-unit model
        drive(1, 1, 0, 0, 0, 0, 0);
        for (int l = 0; l < 5; l++) begin
            for (int g = 0; g < (16 >> l); g++) begin
                for (int p = 0; p < (1 << l); p++) begin
                    int i, a;
                    i = g * (1 << l) + p;
                    a = g * 2 * (1 << l) + p;
                    drive(1, 0, 1, 0, 0, (l == 0), 0);
                    if (i == 0)
                        expect_snap("layer_start", M_RD | M_ST, 0, (l == 0) ? 16 : (1 << l),
                                    0, l, 1, 0, 0, 0, 0);
                    drive(1, 0, 0, 1, (i == 15), (l == 0), 1);
                    expect_wr(a, a + (1 << l));
                    if (l == 4 && i == 15) q_done.push_back(1);
                end
            end
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_snap("done_pulse", M_ALL, 15, 31, 15, 4, 0, 1, 15, 31, 1);
        drive(1, 0, 1, 1, 1, 0, 1);
        expect_snap("idle_after_done", M_ALL, 15, 31, 15, 4, 0, 0, 15, 31, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_snap("idle_strobes_ignored", M_ALL, 15, 31, 15, 4, 0, 0, 15, 31, 0);

        // Async reset mid-transform at layer 3, b=7
        drive(1, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 1, 1, 0);
        drive(1, 0, 0, 1, 1, 0, 0);
        drive(1, 0, 0, 1, 1, 0, 0);
        repeat (7) drive(1, 0, 0, 1, 0, 0, 0);
        drive(1, 0, 1, 0, 0, 0, 0);
        expect_snap("l3_b7_rd", M_RD | M_ST, 7, 15, 14, 3, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 1);
        #2;
        RST = 1'b0;
        #1;
        expect_snap("async_reset", M_ALL, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_snap("reset_held", M_ALL, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        RST = 1'b1;
        drive(1, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 0);
        expect_snap("restart_l0_b0", M_ALL, 0, 16, 0, 0, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 1, 0);
        @(posedge CLK);

        n_vec++;
        if (q_snap.size() != 0) begin
            n_bad++;
            $display("FAIL snap_drain: %0d snapshots left, want 0", q_snap.size());
        end
        n_vec++;
        if (q_wr.size() != 0) begin
            n_bad++;
            $display("FAIL write_drain: %0d writes never seen, want 0", q_wr.size());
        end
        n_vec++;
        if (q_done.size() != 0) begin
            n_bad++;
            $display("FAIL done_drain: %0d DONE pulses never seen, want 0", q_done.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
